// File: rtl/busif85_pkg.sv
// Shared definitions for the core85 bus interface unit.
package busif85_pkg;

  // Width of the wait-state counter; larger parameter values are truncated to this.
  localparam int unsigned WCNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT,
    ST_XFER,
    ST_DRIVE,
    ST_DONE
  } state_t;

  // Machine-cycle codes as {iom_, s1, s0}.
  typedef enum logic [2:0] {
    CYC_HALT = 3'b000,
    CYC_MW   = 3'b001,
    CYC_MR   = 3'b010,
    CYC_OF   = 3'b011,
    CYC_IOW  = 3'b101,
    CYC_IOR  = 3'b110,
    CYC_INTA = 3'b111
  } cyc_t;

  // Wait-state count for a cycle, chosen by address space.
  function automatic logic [WCNT_W-1:0] wait_sel(input logic is_io,
                                                 input logic [WCNT_W-1:0] wmem,
                                                 input logic [WCNT_W-1:0] wio);
    return is_io ? wio : wmem;
  endfunction

endpackage

// File: rtl/busif85_wait.sv
// Loadable wait-state down-counter with a registered READY output.
module busif85_wait
  import busif85_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [WCNT_W-1:0] value_i,
  output logic [WCNT_W-1:0] count_o,
  output logic              done_o,
  output logic              ready_o
);

  localparam logic [WCNT_W-1:0] ONE = WCNT_W'(1);

  logic [WCNT_W-1:0] cnt_q, cnt_d;
  logic              ready_q, ready_d;

  // Load wins; otherwise count down to zero, raising READY as the last wait expires.
  always_comb begin
    cnt_d   = cnt_q;
    ready_d = ready_q;
    if (load_i) begin
      cnt_d   = value_i;
      ready_d = (value_i == '0);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
      if (cnt_q == ONE) ready_d = 1'b1;
    end
  end

  // Counter and READY registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      ready_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign count_o = cnt_q;
  assign done_o  = (cnt_q <= ONE);
  assign ready_o = ready_q;

endmodule

// File: rtl/busif85.sv
// Bus interface unit: core85 multiplexed bus to memory/IO strobes.
module busif85
  import busif85_pkg::*;
#(
  parameter int unsigned WAIT_MEM = 1,
  parameter int unsigned WAIT_IO  = 2,
  parameter logic [7:0]  INT_OPC  = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ad_in,
  output logic [7:0]  ad_out,
  output logic        ad_oe,
  input  logic [7:0]  addrhigh,
  input  logic        ale,
  input  logic        iom_,
  input  logic        s1,
  input  logic        s0,
  input  logic        rd_,
  input  logic        wr_,
  input  logic        inta_,
  output logic        ready,
  output logic [2:0]  cyc,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  io_addr,
  output logic        io_we,
  output logic        io_re,
  input  logic [7:0]  io_rdata,
  output logic        buserr
);

  localparam logic [WCNT_W-1:0] WM = WCNT_W'(WAIT_MEM);
  localparam logic [WCNT_W-1:0] WI = WCNT_W'(WAIT_IO);

  state_t      state_q, state_d;
  logic [2:0]  cyc_q, cyc_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  ad_out_q, ad_out_d;
  logic        ad_oe_q, ad_oe_d;
  logic        mem_re_q, mem_re_d, mem_we_q, mem_we_d;
  logic        io_re_q, io_re_d, io_we_q, io_we_d;
  logic        buserr_q, buserr_d;
  logic        wr_seen_q, wr_seen_d;
  logic        cap_q, cap_d;

  logic [WCNT_W-1:0] wcnt;
  logic              wdone;

  busif85_wait u_wait (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ale),
    .value_i (wait_sel(iom_, WM, WI)),
    .count_o (wcnt),
    .done_o  (wdone),
    .ready_o (ready)
  );

  // Next-state and output decode; ALE overrides every state and restarts the cycle.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ad_out_d  = ad_out_q;
    ad_oe_d   = ad_oe_q;
    buserr_d  = buserr_q;
    wr_seen_d = wr_seen_q;
    cap_d     = 1'b0;
    mem_re_d  = 1'b0;
    mem_we_d  = 1'b0;
    io_re_d   = 1'b0;
    io_we_d   = 1'b0;
    if (ale) begin
      addr_d    = {addrhigh, ad_in};
      cyc_d     = {iom_, s1, s0};
      ad_oe_d   = 1'b0;
      wr_seen_d = 1'b0;
      state_d   = ST_ADDR;
    end else begin
      case (state_q)
        ST_IDLE:  if (!rd_ || !wr_ || !inta_) buserr_d = 1'b1;
        ST_ADDR:  state_d = (wcnt == '0) ? ST_XFER : ST_WAIT;
        ST_WAIT:  if (wdone) state_d = ST_XFER;
        ST_XFER: begin
          if (!rd_ && !wr_) begin
            buserr_d  = 1'b1;
            wr_seen_d = 1'b0;
            state_d   = ST_IDLE;
          end else if (!inta_) begin
            ad_out_d = INT_OPC;
            ad_oe_d  = 1'b1;
            state_d  = ST_DRIVE;
          end else if (!rd_) begin
            if (cyc_q[2]) io_re_d = 1'b1;
            else          mem_re_d = 1'b1;
            state_d = ST_DRIVE;
          end else if (!wr_) begin
            wdata_d   = ad_in;
            wr_seen_d = 1'b1;
          end else if (wr_seen_q) begin
            if (cyc_q[2]) io_we_d = 1'b1;
            else          mem_we_d = 1'b1;
            wr_seen_d = 1'b0;
            state_d   = ST_DONE;
          end
        end
        // Read data is registered by the target on the edge after the strobe,
        // so it is captured one further clock later.
        ST_DRIVE: begin
          if (mem_re_q || io_re_q) begin
            cap_d = 1'b1;
          end else if (cap_q) begin
            ad_out_d = cyc_q[2] ? io_rdata : mem_rdata;
            ad_oe_d  = 1'b1;
          end else if (rd_ && inta_) begin
            ad_oe_d = 1'b0;
            state_d = ST_DONE;
          end
        end
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cyc_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ad_out_q  <= '0;
      ad_oe_q   <= 1'b0;
      mem_re_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      io_re_q   <= 1'b0;
      io_we_q   <= 1'b0;
      buserr_q  <= 1'b0;
      wr_seen_q <= 1'b0;
      cap_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ad_out_q  <= ad_out_d;
      ad_oe_q   <= ad_oe_d;
      mem_re_q  <= mem_re_d;
      mem_we_q  <= mem_we_d;
      io_re_q   <= io_re_d;
      io_we_q   <= io_we_d;
      buserr_q  <= buserr_d;
      wr_seen_q <= wr_seen_d;
      cap_q     <= cap_d;
    end
  end

  assign ad_out    = ad_out_q;
  assign ad_oe     = ad_oe_q;
  assign cyc       = cyc_q;
  assign mem_addr  = addr_q;
  assign io_addr   = addr_q[7:0];
  assign mem_wdata = wdata_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign io_re     = io_re_q;
  assign io_we     = io_we_q;
  assign buserr    = buserr_q;

endmodule

// File: tb/tb_busif85.sv
// Scoreboard bench for busif85: expected bus events are queued by the
// stimulus and matched by an independent monitor as the DUT produces them.
module tb_busif85;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ad_in = '0, addrhigh = '0;
  logic        ale = 1'b0, iom_ = 1'b0, s1 = 1'b0, s0 = 1'b0;
  logic        rd_ = 1'b1, wr_ = 1'b1, inta_ = 1'b1;
  logic [7:0]  mem_rdata = '0, io_rdata = '0, mem_rdata0 = '0, io_rdata0 = '0;
  logic [7:0]  mem_val = '0, io_val = '0;

  logic [7:0]  ad_out, mem_wdata, io_addr;
  logic        ad_oe, ready, mem_we, mem_re, io_we, io_re, buserr;
  logic [2:0]  cyc;
  logic [15:0] mem_addr;

  logic [7:0]  ad_out0, mem_wdata0, io_addr0;
  logic        ad_oe0, ready0, mem_we0, mem_re0, io_we0, io_re0, buserr0;
  logic [2:0]  cyc0;
  logic [15:0] mem_addr0;

  always #5 clk = ~clk;

  busif85 #(.WAIT_MEM(1), .WAIT_IO(2), .INT_OPC(8'hFF)) u_dut (
    .clk(clk), .rst(rst), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
    .addrhigh(addrhigh), .ale(ale), .iom_(iom_), .s1(s1), .s0(s0),
    .rd_(rd_), .wr_(wr_), .inta_(inta_), .ready(ready), .cyc(cyc),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .io_addr(io_addr), .io_we(io_we), .io_re(io_re),
    .io_rdata(io_rdata), .buserr(buserr)
  );

  // Zero-wait memory configuration, used for the opcode-fetch check.
  busif85 #(.WAIT_MEM(0), .WAIT_IO(2), .INT_OPC(8'hFF)) u_dut0 (
    .clk(clk), .rst(rst), .ad_in(ad_in), .ad_out(ad_out0), .ad_oe(ad_oe0),
    .addrhigh(addrhigh), .ale(ale), .iom_(iom_), .s1(s1), .s0(s0),
    .rd_(rd_), .wr_(wr_), .inta_(inta_), .ready(ready0), .cyc(cyc0),
    .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_we(mem_we0), .mem_re(mem_re0),
    .mem_rdata(mem_rdata0), .io_addr(io_addr0), .io_we(io_we0), .io_re(io_re0),
    .io_rdata(io_rdata0), .buserr(buserr0)
  );

  // Registered memory/IO targets: data valid one clock after the read strobe.
  always @(posedge clk) begin
    if (mem_re)  mem_rdata  <= mem_val;
    if (io_re)   io_rdata   <= io_val;
    if (mem_re0) mem_rdata0 <= mem_val;
    if (io_re0)  io_rdata0  <= io_val;
  end

  typedef struct packed {
    logic [2:0]  kind;
    logic [15:0] addr;
    logic [7:0]  data;
  } ev_t;

  localparam logic [2:0] K_MRE = 3'd1, K_MWE = 3'd2, K_IRE = 3'd3, K_IWE = 3'd4, K_DRV = 3'd5;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic ev_t mk(input logic [2:0] k, input logic [15:0] a, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    return e;
  endfunction

  task automatic got(input string name, input ev_t e);
    ev_t x;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_%s: got event 0x%0h, expected none", name, e);
    end else begin
      x = exp_q.pop_front();
      check(name, 32'(e), 32'(x));
    end
  endtask

  // Monitor: every strobe pulse and every rise of ad_oe is one observed event.
  logic       oe_prev   = 1'b0;
  logic [3:0] strb_prev = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_re) begin
        check("mem_re_width", 32'(strb_prev[0]), 32'(0));
        got("mem_re", mk(K_MRE, mem_addr, 8'h00));
      end
      if (mem_we) begin
        check("mem_we_width", 32'(strb_prev[1]), 32'(0));
        got("mem_we", mk(K_MWE, mem_addr, mem_wdata));
      end
      if (io_re) begin
        check("io_re_width", 32'(strb_prev[2]), 32'(0));
        got("io_re", mk(K_IRE, {8'h00, io_addr}, 8'h00));
      end
      if (io_we) begin
        check("io_we_width", 32'(strb_prev[3]), 32'(0));
        got("io_we", mk(K_IWE, {8'h00, io_addr}, mem_wdata));
      end
      if (ad_oe && !oe_prev) got("ad_drive", mk(K_DRV, 16'h0000, ad_out));
    end
    oe_prev   <= ad_oe;
    strb_prev <= {io_we, io_re, mem_we, mem_re};
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Presents ALE for one clock; returns at the negedge after the latching edge.
  task automatic do_ale(input logic [15:0] a, input logic [2:0] c);
    @(negedge clk);
    ale      = 1'b1;
    addrhigh = a[15:8];
    ad_in    = a[7:0];
    {iom_, s1, s0} = c;
    @(negedge clk);
    ale   = 1'b0;
    ad_in = 8'h00;
  endtask

  task automatic count_ready_low(input string name, input int expn);
    int n;
    n = 0;
    while (ready === 1'b0 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check(name, 32'(n), 32'(expn));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"},  32'(ready),     32'(1));
    check({tag, "_ad_oe"},  32'(ad_oe),     32'(0));
    check({tag, "_ad_out"}, 32'(ad_out),    32'(0));
    check({tag, "_cyc"},    32'(cyc),       32'(0));
    check({tag, "_addr"},   32'(mem_addr),  32'(0));
    check({tag, "_wdata"},  32'(mem_wdata), 32'(0));
    check({tag, "_strb"},   32'({mem_we, mem_re, io_we, io_re}), 32'(0));
    check({tag, "_buserr"}, 32'(buserr),    32'(0));
  endtask

  initial begin
    int low0, re0;
    tick(2);
    check_reset_vals("rst_hold");
    rst = 1'b0;
    tick(2);
    check_reset_vals("rst_idle");

    // Memory read, one wait state.
    mem_val = 8'h5A;
    do_ale(16'h1234, 3'b010);
    check("t1_mem_addr", 32'(mem_addr), 32'h1234);
    check("t1_cyc", 32'(cyc), 32'(3'b010));
    exp_q.push_back(mk(K_MRE, 16'h1234, 8'h00));
    exp_q.push_back(mk(K_DRV, 16'h0000, 8'h5A));
    count_ready_low("t1_ready_low", 1);
    rd_ = 1'b0;
    tick(6);
    check("t1_ad_oe_held", 32'(ad_oe), 32'(1));
    check("t1_ad_out", 32'(ad_out), 32'h5A);
    rd_ = 1'b1;
    tick(2);
    check("t1_ad_oe_release", 32'(ad_oe), 32'(0));
    tick(1);

    // IO write, two wait states; last data value before wr_ rises is kept.
    do_ale(16'h4040, 3'b101);
    check("t2_io_addr", 32'(io_addr), 32'h40);
    exp_q.push_back(mk(K_IWE, 16'h0040, 8'hA5));
    count_ready_low("t2_ready_low", 2);
    wr_ = 1'b0; ad_in = 8'h11;
    tick(1); ad_in = 8'h22;
    tick(1); ad_in = 8'hA5;
    tick(1); wr_ = 1'b1; ad_in = 8'h00;
    tick(3);
    check("t2_wdata", 32'(mem_wdata), 32'hA5);

    // Opcode fetch: zero-wait instance must never drop READY.
    mem_val = 8'h3C;
    do_ale(16'h0100, 3'b011);
    exp_q.push_back(mk(K_MRE, 16'h0100, 8'h00));
    exp_q.push_back(mk(K_DRV, 16'h0000, 8'h3C));
    rd_ = 1'b0;
    low0 = 0;
    re0  = 0;
    for (int i = 0; i < 8; i++) begin
      if (ready0 === 1'b0) low0++;
      if (mem_re0 === 1'b1) re0++;
      tick(1);
    end
    check("t3_zw_ready_low", 32'(low0), 32'(0));
    check("t3_zw_mem_re_pulses", 32'(re0), 32'(1));
    check("t3_zw_ad_out", 32'({ad_oe0, ad_out0}), 32'h13C);
    check("t3_ad_out", 32'({ad_oe, ad_out}), 32'h13C);
    rd_ = 1'b1;
    tick(3);

    // Interrupt acknowledge: RST 7 opcode, no memory/IO strobes.
    do_ale(16'h0000, 3'b111);
    exp_q.push_back(mk(K_DRV, 16'h0000, 8'hFF));
    count_ready_low("t4_ready_low", 2);
    inta_ = 1'b0;
    tick(2);
    check("t4_inta_drive", 32'({ad_oe, ad_out}), 32'h1FF);
    inta_ = 1'b1;
    tick(2);
    check("t4_inta_release", 32'(ad_oe), 32'(0));
    tick(1);

    // Abort: a second ALE during the wait reloads the full count; then an IO read.
    io_val = 8'hC3;
    do_ale(16'h5555, 3'b110);
    do_ale(16'h6677, 3'b110);
    check("t5_abort_addr", 32'(mem_addr), 32'h6677);
    exp_q.push_back(mk(K_IRE, 16'h0077, 8'h00));
    exp_q.push_back(mk(K_DRV, 16'h0000, 8'hC3));
    count_ready_low("t5_ready_low_reload", 2);
    rd_ = 1'b0;
    tick(6);
    check("t5_io_read", 32'({ad_oe, ad_out}), 32'h1C3);
    rd_ = 1'b1;
    tick(3);

    // Reset in the middle of a write: values return at once, no write issued.
    do_ale(16'h2000, 3'b001);
    count_ready_low("t6_ready_low", 1);
    wr_ = 1'b0; ad_in = 8'h77;
    tick(2);
    check("t6_wdata_pending", 32'(mem_wdata), 32'h77);
    #2 rst = 1'b1;
    #1 check_reset_vals("t6_async");
    wr_ = 1'b1; ad_in = 8'h00;
    tick(2);
    rst = 1'b0;
    tick(3);

    // Simultaneous rd_/wr_ is a sticky error with no strobes.
    do_ale(16'h3000, 3'b010);
    count_ready_low("t7_ready_low", 1);
    rd_ = 1'b0; wr_ = 1'b0;
    tick(3);
    check("t7_buserr", 32'(buserr), 32'(1));
    rd_ = 1'b1; wr_ = 1'b1;
    tick(3);
    check("t7_buserr_sticky", 32'(buserr), 32'(1));
    rst = 1'b1;
    tick(1);
    check("t7_buserr_cleared", 32'(buserr), 32'(0));
    rst = 1'b0;
    tick(1);

    // Strobe with no preceding ALE.
    rd_ = 1'b0;
    tick(2);
    check("t8_stray_strobe_err", 32'(buserr), 32'(1));
    rd_ = 1'b1;
    tick(3);

    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
